// File: rtl/charmquark1984_seg_pkg.sv
// rtl/charmquark1984_seg_pkg.sv - shared seven-segment constants and lock state type
// Used by the segment controller and the segment reader.
// Segment bit order is gfedcba (bit0 = a, bit6 = g), active-high.
package charmquark1984_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

endpackage

// File: rtl/charmquark1984_seg_decode.sv
// rtl/charmquark1984_seg_decode.sv - combinational seven-segment pattern to BCD decoder
// Ports:
//   pattern  [6:0] in  segment pattern, gfedcba
//   digit    [3:0] out decoded digit (0 when not a legal digit)
//   is_legal       out pattern is one of the ten digit patterns
//   is_blank       out pattern is all segments off
module charmquark1984_seg_decode
    import charmquark1984_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       is_legal,
    output logic       is_blank
);

    always_comb begin
        digit    = 4'd0;
        is_legal = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: begin
                is_legal = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/charmquark1984_segment_reader.sv
// rtl/charmquark1984_segment_reader.sv - glitch-filtered seven-segment bus monitor and decoder
// Optional feature macro: SEGREADER_SEQ_CHECK_EN (digit sequence checking, drives seq_error).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   segments    [6:0]   sampled segment lines, gfedcba
//   digit       [3:0]   last accepted digit
//   digit_valid         one-cycle pulse on a newly accepted digit
//   invalid             one-cycle pulse on a newly accepted illegal pattern
//   seq_error           one-cycle pulse on an out-of-sequence digit while locked
//   locked              lock state indicator
//   event_count [COUNT_W-1:0] accepted digit count, wrapping
module charmquark1984_segment_reader
    import charmquark1984_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         segments,
    output logic [3:0]         digit,
    output logic               digit_valid,
    output logic               invalid,
    output logic               seq_error,
    output logic               locked,
    output logic [COUNT_W-1:0] event_count
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_ACC = 4'(STABLE_CYCLES - 1);

    logic [6:0] s_q;
    logic [6:0] cand;
    logic [6:0] last_pat;
    logic [3:0] cnt;
    logic       accept;
    logic       fresh;
    logic [3:0] dec_digit;
    logic       dec_legal;
    logic       dec_blank;
    state_t     state_q;
    state_t     state_d;
    logic       dv_d;
    logic       inv_d;
    logic       se_d;

    // Input register plus stability window; cnt saturates so that accept
    // fires only on the single cycle where the run reaches full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= SEG_BLANK;
            cand <= SEG_BLANK;
            cnt  <= 4'd0;
        end else begin
            s_q <= segments;
            if (s_q != cand) begin
                cand <= s_q;
                cnt  <= 4'd1;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign accept = (s_q == cand) && (cnt == CNT_ACC);
    // Re-accepting the pattern already on record is silent, which hides
    // glitches that return to the same pattern.
    assign fresh  = accept && (cand != last_pat);

    charmquark1984_seg_decode u_decode (
        .pattern  (cand),
        .digit    (dec_digit),
        .is_legal (dec_legal),
        .is_blank (dec_blank)
    );

`ifdef SEGREADER_SEQ_CHECK_EN
    logic [3:0] next_digit;
    assign next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
`endif

    always_comb begin
        state_d = state_q;
        dv_d    = 1'b0;
        inv_d   = 1'b0;
        se_d    = 1'b0;
        if (fresh) begin
            if (dec_legal) begin
                dv_d    = 1'b1;
                state_d = LOCKED;
`ifdef SEGREADER_SEQ_CHECK_EN
                se_d    = (state_q == LOCKED) && (dec_digit != next_digit);
`endif
            end else if (!dec_blank) begin
                inv_d   = 1'b1;
                state_d = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            last_pat    <= SEG_BLANK;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            invalid     <= 1'b0;
            event_count <= '0;
        end else begin
            state_q     <= state_d;
            digit_valid <= dv_d;
            invalid     <= inv_d;
            if (fresh) begin
                last_pat <= cand;
            end
            if (dv_d) begin
                digit       <= dec_digit;
                event_count <= event_count + 1'b1;
            end
        end
    end

`ifdef SEGREADER_SEQ_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_error <= 1'b0;
        end else begin
            seq_error <= se_d;
        end
    end
`else
    assign seq_error = 1'b0;
    logic unused_se;
    assign unused_se = se_d;
`endif

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_charmquark1984_segment_reader.sv
// tb/tb_charmquark1984_segment_reader.sv - scoreboard bench for the segment reader
module tb_charmquark1984_segment_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segments;
    logic [3:0] digit, digit3;
    logic       digit_valid, invalid, seq_error, locked;
    logic       digit_valid3, invalid3, seq_error3, locked3;
    logic [7:0] event_count;
    logic [2:0] event_count3;

    always #5 clk = ~clk;

    charmquark1984_segment_reader #(.STABLE_CYCLES(4), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .segments(segments), .digit(digit),
        .digit_valid(digit_valid), .invalid(invalid), .seq_error(seq_error),
        .locked(locked), .event_count(event_count)
    );

    charmquark1984_segment_reader #(.STABLE_CYCLES(4), .COUNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .segments(segments), .digit(digit3),
        .digit_valid(digit_valid3), .invalid(invalid3), .seq_error(seq_error3),
        .locked(locked3), .event_count(event_count3)
    );

    typedef struct {
        logic       inv;
        logic [3:0] dig;
        logic       se;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int exp_count = 0;

`ifdef SEGREADER_SEQ_CHECK_EN
    localparam logic SE_ON = 1'b1;
`else
    localparam logic SE_ON = 1'b0;
`endif

    localparam logic [6:0] PATS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic inv, input logic [3:0] dig, input logic se);
        exp_t e;
        e.inv = inv;
        e.dig = dig;
        e.se  = se;
        q.push_back(e);
    endtask

    // Called once per negedge: pops the scoreboard on every pulse.
    task automatic check_outputs();
        exp_t e;
        if (digit_valid && invalid) chk("dv_inv_overlap", 1, 0);
        if (seq_error && !digit_valid) chk("stray_seq_error", 1, 0);
        if (digit_valid || invalid) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {digit_valid, invalid}, 0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", {31'd0, invalid}, {31'd0, e.inv});
                chk("pulse_digit", {28'd0, digit}, {28'd0, e.dig});
                chk("pulse_seq_error", {31'd0, seq_error}, {31'd0, e.se});
            end
        end
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        segments = pat;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic send_digit(input logic [6:0] pat, input logic [3:0] d, input logic se);
        push(1'b0, d, se);
        exp_count++;
        hold(pat, 10);
    endtask

    // Counts negedges from the drive until digit_valid, bounded.
    task automatic measure(input logic [6:0] pat, output int n);
        segments = pat;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (digit_valid && n < 0) n = i;
            check_outputs();
        end
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        segments = 7'h00;
        repeat (3) @(negedge clk);
        chk("rst_digit", {28'd0, digit}, 0);
        chk("rst_digit_valid", {31'd0, digit_valid}, 0);
        chk("rst_invalid", {31'd0, invalid}, 0);
        chk("rst_seq_error", {31'd0, seq_error}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_event_count", {24'd0, event_count}, 0);
        rst = 1'b0;

        // Steady blank after reset release: silent.
        hold(7'h00, 8);
        chk("blank_locked", {31'd0, locked}, 0);

        // Clean count 0..9,0.
        for (int k = 0; k < 10; k++) begin
            send_digit(PATS[k], 4'(k), 1'b0);
            if (k == 0) chk("locked_after_first", {31'd0, locked}, 1);
            if (k == 8) chk("wrap_count3", {29'd0, event_count3}, 1);
        end
        send_digit(7'h3F, 4'd0, 1'b0);
        chk("clean_count", {24'd0, event_count}, 32'(exp_count));
        chk("clean_locked", {31'd0, locked}, 1);

        // Glitch filter.
        send_digit(7'h06, 4'd1, 1'b0);
        hold(7'h7F, 3);
        hold(7'h06, 10);
        chk("glitch_digit", {28'd0, digit}, 1);

        // Illegal pattern while locked on 5.
        send_digit(7'h5B, 4'd2, 1'b0);
        send_digit(7'h4F, 4'd3, 1'b0);
        send_digit(7'h66, 4'd4, 1'b0);
        send_digit(7'h6D, 4'd5, 1'b0);
        push(1'b1, 4'd5, 1'b0);
        hold(7'h49, 6);
        chk("illegal_locked", {31'd0, locked}, 0);
        chk("illegal_digit", {28'd0, digit}, 5);
        chk("illegal_count", {24'd0, event_count}, 32'(exp_count));
        send_digit(7'h7D, 4'd6, 1'b0);
        chk("relock", {31'd0, locked}, 1);

        // Sequence skips.
        send_digit(7'h5B, 4'd2, SE_ON);
        send_digit(7'h66, 4'd4, SE_ON);
        send_digit(7'h6D, 4'd5, 1'b0);
        chk("skip_locked", {31'd0, locked}, 1);

        // Latency: 5 -> 0 is also out of sequence.
        push(1'b0, 4'd0, SE_ON);
        exp_count++;
        measure(7'h3F, lat);
        chk("latency", 32'(lat), 5);
        chk("latency_count", {24'd0, event_count}, 32'(exp_count));

        // Asynchronous reset mid-window.
        segments = 7'h06;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_locked", {31'd0, locked}, 0);
        chk("async_count", {24'd0, event_count}, 0);
        chk("async_digit", {28'd0, digit}, 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_count = 0;
        push(1'b0, 4'd1, 1'b0);
        exp_count++;
        measure(7'h06, lat);
        chk("post_reset_latency", 32'(lat), 5);
        chk("post_reset_count", {24'd0, event_count}, 32'(exp_count));

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/charmquark1984_segment_reader.md
# charmquark1984_segment_reader

Receive-side monitor for the seven-segment bus driven by `charmquark1984_controller`. It samples the 7-bit segment lines, filters glitches with a stability window, and decodes each new stable pattern back to a BCD digit. It flags illegal patterns and out-of-sequence digits, and counts accepted digits. The block sits beside the controller in the test harness, or in silicon as a loopback checker on `io_out[6:0]`.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted. Legal range is 2..15.
- `COUNT_W`, default 8: width of the accepted-digit counter.

Ports:
- `clk`  input  1  single clock; all state advances on its rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `segments`  input  7  segment lines, active-high. bit0 = a through bit6 = g.
- `digit`  output  4  last accepted digit, 0..9.
- `digit_valid`  output  1  one-cycle pulse when a new digit is accepted.
- `invalid`  output  1  one-cycle pulse when an illegal pattern is accepted.
- `seq_error`  output  1  one-cycle pulse when an accepted digit ≠ (previous + 1) mod 10 while LOCKED.
- `locked`  output  1  high in the LOCKED state.
- `event_count`  output  COUNT_W  number of accepted digits, wraps modulo 2^COUNT_W.

## Operation
- **Legal patterns (gfedcba):** 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- **Blank:** 0x00 is neutral.
- **Illegal:** every other value.
- **Input stage:** `s_q <= segments` every cycle.
- **Stability filter:**
  - If `s_q != cand`: `cand <= s_q`, `cnt <= 1`.
  - Otherwise, if `cnt < STABLE_CYCLES`: `cnt <= cnt + 1`. `cnt` saturates at STABLE_CYCLES.
  - Accept event: `s_q == cand` and `cnt == STABLE_CYCLES-1`. This fires exactly once per stable run.
- **On accept, when the pattern equals `last_pat`:** no effect, no pulses. This makes a glitch that returns to the same pattern invisible.
- **Otherwise, on accept:** `last_pat <= pattern`, then:
  - **Blank:** no pulses, state unchanged.
  - **Legal:**
    - `digit` is updated and `digit_valid` pulses.
    - `event_count` increments.
    - UNLOCKED → LOCKED.
    - If already LOCKED and digit ≠ (previous digit + 1) mod 10: `seq_error` pulses and the block stays LOCKED, resynchronised to the new digit.
  - **Illegal:** `invalid` pulses and the state goes to UNLOCKED. `digit` and `event_count` hold.
- **FSM:** two states, UNLOCKED and LOCKED. `locked` = (state == LOCKED).
- **Wrap rules:**
  - The digit sequence 9→0 is in sequence.
  - `event_count` wraps from all-ones to 0 with no flag.

## Timing
- All outputs are registered.
- Reset values:
  - `s_q`, `cand`, `cnt`, `last_pat`: 0x00 / 0.
  - `digit` = 0, `digit_valid` = 0, `invalid` = 0, `seq_error` = 0, `event_count` = 0.
  - State = UNLOCKED, `locked` = 0.
- **Latency:** a change on `segments` that is set up before edge E and held steady produces pulses during the cycle after edge E+STABLE_CYCLES. For the default parameter, that is 5 edges after the change.
- **Pulse width:** each pulse is exactly one cycle. `digit_valid` and `seq_error` can be high in the same cycle. `invalid` is never high together with either of them.
- **Short glitches:** a glitch shorter than STABLE_CYCLES samples is never accepted.
- **Reset mid-window:** asserting reset clears the partial stability count. A pattern in progress needs a full window after reset deasserts.
- **Reset release:** a steady blank is accepted silently.

## Configuration
- Macro: `SEGREADER_SEQ_CHECK_EN`.
- **Defined:** sequence checking as described above.
- **Undefined:**
  - `seq_error` is tied to 0.
  - No previous-digit comparison logic is built.
  - LOCKED means only "a legal digit was seen since the last illegal pattern or reset".

## Structure
- Shared package `charmquark1984_seg_pkg`, used by both the controller and this reader:
  - the ten digit segment constants and the blank constant;
  - the `state_t` enum {UNLOCKED, LOCKED}.
- Sub-module `charmquark1984_seg_decode`: combinational, `pattern[6:0]` → `digit[3:0]`, `is_legal`, `is_blank`.
- The filter, the FSM and the counters live in the top module.

## Test plan
- **Clean count:** reset, then drive 0x3F, 0x06, 0x5B, …, 0x6F, 0x3F, each held 10 cycles.
  - 11 `digit_valid` pulses, digits 0..9,0.
  - `seq_error` = 0 throughout; `event_count` = 11; `locked` = 1 after the first pulse.
- **Glitch filter:** hold 0x06, insert 0x7F for 3 cycles (STABLE_CYCLES=4), return to 0x06.
  - No pulses after the first acceptance; `digit` stays 1.
- **Illegal pattern:** while locked on 5, hold 0x49 for 6 cycles.
  - One `invalid` pulse and `locked` → 0; `digit` holds 5.
  - Then 0x7D gives `digit_valid` with `digit` = 6, `locked` = 1, and no `seq_error`.
- **Sequence skip:** locked on 2 (0x5B), then 0x66.
  - `digit_valid` and `seq_error` both pulse in the same cycle, `digit` = 4.
  - Then 0x6D gives no error.
  - With the macro undefined, `seq_error` never asserts.
- **Latency and reset:**
  - A change to 0x3F set up before edge E gives `digit_valid` during the cycle after edge E+4.
  - Asserting `rst` asynchronously after 2 stable samples clears every output immediately.
  - After release, 0x3F needs another full window before it is accepted.
- **Counter wrap:** with COUNT_W=3, 9 in-sequence digits give `event_count` = 1 and no flags.
